result_accumulator: RTL
=======================

Name: result_accumulator

Overview:
- Downstream stage of the datapath register block. Consumes its WIDTH-bit data_out and 1-bit out flag through a valid/ready handshake.
- Accumulates COUNT samples into a MUL_WIDTH-wide saturating sum and counts how many samples arrived with the flag set.
- Presents one result word per block to the next consumer through its own valid/ready handshake.

Parameters:
- WIDTH, 8, sample width; matches the upstream data_out width.
- MUL_WIDTH, WIDTH*2, accumulator and result width; legal range WIDTH+1 and up.
- COUNT, 4, samples per block; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- data_in  input  WIDTH  sample from the upstream stage; unsigned.
- flag_in  input  1  upstream out flag for the same sample.
- in_valid  input  1  sample present on data_in/flag_in.
- in_ready  output  1  block accepts a sample this cycle.
- flush  input  1  emit a partial block early.
- data_out  output  MUL_WIDTH  accumulated sum of the block.
- flag_count  output  8  number of accepted samples in the block with flag_in=1.
- ovf  output  1  accumulator saturated during this block.
- out_valid  output  1  result on data_out/flag_count/ovf is valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over all other inputs, including mid-block and mid-HOLD. Next state:
  - state=IDLE; acc, sample counter, flag_count, data_out, ovf = 0.
  - out_valid=0, in_ready=1.
  - Any partially accumulated block is discarded.
- States: IDLE (no samples yet), ACCUM (1..COUNT-1 samples taken), HOLD (result presented).
- Accept condition: in_valid && in_ready. in_ready=1 in IDLE and ACCUM, 0 in HOLD; it is a registered state decode and does not depend on in_valid.
- On accept:
  - acc_next = acc + zero-extended data_in.
  - If the true sum exceeds 2^MUL_WIDTH-1, acc is set to 2^MUL_WIDTH-1 and ovf is set. ovf is sticky until the block is handed off.
  - The sample counter increments; flag_count increments if flag_in=1.
- Block completes on the accept that makes the sample count equal COUNT.
  - Next cycle: state=HOLD, out_valid=1, data_out = final acc.
  - flag_count and ovf hold their final values.
  - Latency: result valid 1 cycle after the last accepted sample.
- COUNT=1: every accept goes IDLE->HOLD directly.
- Flush:
  - In ACCUM: the block completes as above with the partial count.
  - flush together with an accept in IDLE or ACCUM: the sample is included, then the block completes.
  - flush in IDLE with no accept: ignored, no empty result is ever emitted.
  - flush in HOLD: ignored.
- HOLD:
  - data_out, flag_count and ovf are stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: next cycle out_valid=0, state=IDLE, and acc, counter, flag_count and ovf are cleared.
  - data_out keeps its last value until overwritten by the next block completion.
- No back-to-back overlap: a new block starts accumulating only after the HOLD handoff. Throughput is COUNT+1 cycles per block minimum.
- in_valid while in_ready=0 is not an accept. The upstream holds the sample; nothing is dropped or duplicated.
- flag_count width is fixed at 8 bits; it cannot overflow because COUNT<=255.

Test Plan:
1. Reset, then accept 10,20,30,40 back-to-back (flags 1,0,1,1), out_ready=1 -> one cycle after the 4th accept: out_valid=1, data_out=100, flag_count=3, ovf=0. Next cycle out_valid=0 and in_ready=1.
2. Hold out_ready=0 for 5 cycles after completion -> out_valid stays 1, data_out=100 stable, in_ready=0, in_valid pulses ignored. Raising out_ready gives a single handoff.
3. MUL_WIDTH=9, accept 255,255,255,1 -> data_out=511, ovf=1. The next block of 1,1,1,1 gives data_out=4, ovf=0.
4. Accept 7, 8, then flush together with a third sample 9 -> data_out=24, flag_count matches the flags. flush in IDLE alone -> out_valid stays 0.
5. Accept 2 samples, assert rst for 1 cycle, then accept 1,2,3,4 -> data_out=10. Reset during HOLD -> out_valid=0 on the next cycle.
6. COUNT=1, stream 5,6 with out_ready=1 -> results 5 then 6, in_ready alternating 1/0 each cycle.

Source files
------------

// File: rtl/result_accumulator.sv
// rtl/result_accumulator.sv - saturating block accumulator with flag counter and result handshake
module result_accumulator #(
   parameter int WIDTH     = 8,
   parameter int MUL_WIDTH = WIDTH * 2,
   parameter int COUNT     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 flag_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [MUL_WIDTH-1:0] data_out,
   output logic [7:0]           flag_count,
   output logic                 ovf,
   output logic                 out_valid,
   input  logic                 out_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] COUNT_V = 8'(COUNT);

   state_t               state_q, state_d;
   logic [MUL_WIDTH-1:0] acc_q, acc_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [7:0]           flag_cnt_q, flag_cnt_d;
   logic                 ovf_q, ovf_d;
   logic [MUL_WIDTH-1:0] data_out_q, data_out_d;

   logic                 accept;
   logic [MUL_WIDTH:0]   sum_w;
   logic [MUL_WIDTH-1:0] acc_sat;
   logic [7:0]           cnt_inc;

   // Handshake signals are pure decodes of the registered state.
   assign in_ready   = (state_q != S_HOLD);
   assign out_valid  = (state_q == S_HOLD);
   assign accept     = in_valid && in_ready;
   assign data_out   = data_out_q;
   assign flag_count = flag_cnt_q;
   assign ovf        = ovf_q;

   // Next-state, saturating accumulate, block completion and handoff.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      flag_cnt_d = flag_cnt_q;
      ovf_d      = ovf_q;
      data_out_d = data_out_q;
      // One extra bit catches the carry that signals saturation.
      sum_w      = {1'b0, acc_q} + {{(MUL_WIDTH + 1 - WIDTH){1'b0}}, data_in};
      acc_sat    = sum_w[MUL_WIDTH] ? {MUL_WIDTH{1'b1}} : sum_w[MUL_WIDTH-1:0];
      cnt_inc    = cnt_q + 8'd1;

      case (state_q)
         S_IDLE, S_ACCUM: begin
            if (accept) begin
               acc_d = acc_sat;
               ovf_d = ovf_q | sum_w[MUL_WIDTH];
               cnt_d = cnt_inc;
               if (flag_in) begin
                  flag_cnt_d = flag_cnt_q + 8'd1;
               end
               if ((cnt_inc == COUNT_V) || flush) begin
                  state_d    = S_HOLD;
                  data_out_d = acc_sat;
               end else begin
                  state_d = S_ACCUM;
               end
            end else if (flush && (state_q == S_ACCUM)) begin
               // Partial block; a flush with nothing accumulated is ignored.
               state_d    = S_HOLD;
               data_out_d = acc_q;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d    = S_IDLE;
               acc_d      = '0;
               cnt_d      = '0;
               flag_cnt_d = '0;
               ovf_d      = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-high reset discarding any block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         flag_cnt_q <= '0;
         ovf_q      <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         flag_cnt_q <= flag_cnt_d;
         ovf_q      <= ovf_d;
         data_out_q <= data_out_d;
      end
   end

endmodule
